// File: rtl/mem_copy_engine.sv
// Word-at-a-time data-memory copy/fill engine: IDLE -> (READ -> WRITE)* -> DONE.
// Every memory-side strobe, address and data word, plus busy and done, is a flop.
module mem_copy_engine #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              Fill,
    input  logic [ADDR_W-1:0] SrcAddr,
    input  logic [ADDR_W-1:0] DstAddr,
    input  logic [ADDR_W:0]   Length,
    input  logic [DATA_W-1:0] FillData,
    output logic              busy,
    output logic              done,
    output logic              MemWrite,
    output logic              MemRead,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] Write_data,
    input  logic [DATA_W-1:0] Read_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   src_q;
    logic [ADDR_W-1:0]   dst_q;
    logic [ADDR_W:0]     len_q;
    logic                fill_q;
    logic [DATA_W-1:0]   fdata_q;
    logic [ADDR_W:0]     idx_q;
    logic                busy_q;
    logic                done_q;
    logic                mem_wr_q;
    logic                mem_rd_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic [ADDR_W:0]     idx_inc_d;
    logic [ADDR_W-1:0]   src_next_d;
    logic [ADDR_W-1:0]   dst_cur_d;
    logic [ADDR_W-1:0]   dst_next_d;

    // Word-index increment and the modulo-2^ADDR_W addresses derived from it.
    always_comb begin
        idx_inc_d  = idx_q + (ADDR_W+1)'(1);
        src_next_d = src_q + idx_inc_d[ADDR_W-1:0];
        dst_cur_d  = dst_q + idx_q[ADDR_W-1:0];
        dst_next_d = dst_q + idx_inc_d[ADDR_W-1:0];
    end

    // Transfer FSM; outputs are loaded together with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            fill_q   <= 1'b0;
            fdata_q  <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mem_wr_q <= 1'b0;
            mem_rd_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        src_q   <= SrcAddr;
                        dst_q   <= DstAddr;
                        len_q   <= Length;
                        fill_q  <= Fill;
                        fdata_q <= FillData;
                        idx_q   <= '0;
                        if (Length == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (Fill) begin
                            state_q  <= WRITE;
                            busy_q   <= 1'b1;
                            mem_wr_q <= 1'b1;
                            addr_q   <= DstAddr;
                            wdata_q  <= FillData;
                        end else begin
                            state_q  <= READ;
                            busy_q   <= 1'b1;
                            mem_rd_q <= 1'b1;
                            addr_q   <= SrcAddr;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                READ: begin
                    // wdata_q doubles as the data register for copies.
                    state_q  <= WRITE;
                    wdata_q  <= Read_data;
                    mem_rd_q <= 1'b0;
                    mem_wr_q <= 1'b1;
                    addr_q   <= dst_cur_d;
                end
                WRITE: begin
                    idx_q <= idx_inc_d;
                    if (idx_inc_d == len_q) begin
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        mem_wr_q <= 1'b0;
                    end else if (fill_q) begin
                        state_q <= WRITE;
                        addr_q  <= dst_next_d;
                        wdata_q <= fdata_q;
                    end else begin
                        state_q  <= READ;
                        mem_wr_q <= 1'b0;
                        mem_rd_q <= 1'b1;
                        addr_q   <= src_next_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    mem_wr_q <= 1'b0;
                    mem_rd_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign MemWrite   = mem_wr_q;
    assign MemRead    = mem_rd_q;
    assign Address    = addr_q;
    assign Write_data = wdata_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: stimulus queues expected reads, writes and
// done cycles; a negedge monitor pops and compares whenever the DUT strobes.
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        Fill = 1'b0;
    logic [7:0]  SrcAddr = 8'd0;
    logic [7:0]  DstAddr = 8'd0;
    logic [8:0]  Length = 9'd0;
    logic [31:0] FillData = 32'd0;
    logic        busy, done, MemWrite, MemRead;
    logic [7:0]  Address;
    logic [31:0] Write_data;
    logic [31:0] Read_data;

    logic [31:0] mem [0:255];
    int          cyc = 0;
    int          ntests = 0;
    int          nfail = 0;

    logic [7:0]  rq [$];
    logic [7:0]  wq_a [$];
    logic [31:0] wq_d [$];
    int          dq [$];

    mem_copy_engine #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .Fill(Fill),
        .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Length(Length), .FillData(FillData),
        .busy(busy), .done(done), .MemWrite(MemWrite), .MemRead(MemRead),
        .Address(Address), .Write_data(Write_data), .Read_data(Read_data)
    );

    always #5 clk = ~clk;

    assign Read_data = mem[Address];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (MemWrite) mem[Address] <= Write_data;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: per-cycle strobe exclusivity plus scoreboard pops on each strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            check("rd_wr_exclusive", {63'd0, MemRead && MemWrite}, 64'd0);
            if (MemRead) begin
                if (rq.size() == 0) check("unexpected_read", 64'd1, 64'd0);
                else check("read_addr", {56'd0, Address}, {56'd0, rq.pop_front()});
            end
            if (MemWrite) begin
                if (wq_a.size() == 0) check("unexpected_write", 64'd1, 64'd0);
                else begin
                    check("write_addr", {56'd0, Address}, {56'd0, wq_a.pop_front()});
                    check("write_data", {32'd0, Write_data}, {32'd0, wq_d.pop_front()});
                end
            end
            if (done) begin
                check("busy_in_done", {63'd0, busy}, 64'd0);
                if (dq.size() == 0) check("unexpected_done", 64'd1, 64'd0);
                else check("done_cycle", 64'(cyc), 64'(dq.pop_front()));
            end
        end
    end

    task automatic push_w(input logic [7:0] a, input logic [31:0] d);
        wq_a.push_back(a);
        wq_d.push_back(d);
    endtask

    // Called at a negedge; the following posedge is the start edge.
    task automatic launch(input logic f, input logic [7:0] s, input logic [7:0] d,
                          input logic [8:0] n, input logic [31:0] fd, input int lat);
        Fill = f; SrcAddr = s; DstAddr = d; Length = n; FillData = fd;
        start = 1'b1;
        dq.push_back(cyc + lat);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish(input string name, input int lat);
        repeat (lat + 1) @(negedge clk);
        check({name, "_writes_left"}, 64'(wq_a.size()), 64'd0);
        check({name, "_reads_left"}, 64'(rq.size()), 64'd0);
        check({name, "_done_left"}, 64'(dq.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"}, {63'd0, busy}, 64'd0);
        check({name, "_done"}, {63'd0, done}, 64'd0);
        check({name, "_memread"}, {63'd0, MemRead}, 64'd0);
        check({name, "_memwrite"}, {63'd0, MemWrite}, 64'd0);
        check({name, "_address"}, {56'd0, Address}, 64'd0);
        check({name, "_wdata"}, {32'd0, Write_data}, 64'd0);
    endtask

    initial begin
        bit found;
        for (int k = 0; k < 256; k++) mem[k] = 32'd0;
        mem[5]  = 32'd32;  mem[6]  = 32'd104;
        mem[20] = 32'd7;   mem[21] = 32'h11; mem[22] = 32'h22; mem[23] = 32'h33;
        mem[30] = 32'hAAAA; mem[31] = 32'hBBBB;
        mem[40] = 32'd1; mem[41] = 32'd2; mem[42] = 32'd3; mem[43] = 32'd4;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Start on the very first edge after reset release.
        rq.push_back(8'd5); rq.push_back(8'd6);
        push_w(8'd15, 32'd32); push_w(8'd16, 32'd104);
        rst_n = 1'b1;
        launch(1'b0, 8'd5, 8'd15, 9'd2, 32'd0, 5);
        finish("copy2", 5);
        check("copy2_mem15", {32'd0, mem[15]}, 64'd32);
        check("copy2_mem16", {32'd0, mem[16]}, 64'd104);

        // Fill wrapping past address 255.
        for (int k = 0; k < 8; k++) push_w(8'(250 + k), 32'hDEADBEEF);
        launch(1'b1, 8'd0, 8'd250, 9'd8, 32'hDEADBEEF, 9);
        finish("fill_wrap", 9);
        check("fill_mem255", {32'd0, mem[255]}, 64'hDEADBEEF);
        check("fill_mem1", {32'd0, mem[1]}, 64'hDEADBEEF);
        check("fill_mem2", {32'd0, mem[2]}, 64'd0);

        launch(1'b0, 8'd5, 8'd15, 9'd0, 32'd0, 1);
        finish("len0", 1);
        check("len0_mem15", {32'd0, mem[15]}, 64'd32);

        // Overlapping copy dst=src+1: word 20 propagates forward.
        rq.push_back(8'd20); rq.push_back(8'd21); rq.push_back(8'd22);
        push_w(8'd21, 32'd7); push_w(8'd22, 32'd7); push_w(8'd23, 32'd7);
        launch(1'b0, 8'd20, 8'd21, 9'd3, 32'd0, 7);
        finish("overlap", 7);
        check("overlap_mem23", {32'd0, mem[23]}, 64'd7);

        // A second start while busy must be ignored.
        rq.push_back(8'd30); rq.push_back(8'd31);
        push_w(8'd70, 32'hAAAA); push_w(8'd71, 32'hBBBB);
        launch(1'b0, 8'd30, 8'd70, 9'd2, 32'd0, 5);
        @(negedge clk);
        Fill = 1'b1; DstAddr = 8'd100; Length = 9'd5; FillData = 32'h99; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish("ignore_start", 3);
        check("ignore_mem71", {32'd0, mem[71]}, 64'hBBBB);
        check("ignore_mem100", {32'd0, mem[100]}, 64'd0);

        // Reset during the write of word 2 of 4.
        rq.push_back(8'd40); rq.push_back(8'd41); rq.push_back(8'd42);
        push_w(8'd60, 32'd1); push_w(8'd61, 32'd2);
        launch(1'b0, 8'd40, 8'd60, 9'd4, 32'd0, 9);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (MemRead && Address == 8'd42) found = 1'b1;
            else @(negedge clk);
        end
        check("abort_reached_word2", {63'd0, found}, 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        dq.delete();
        check("abort_writes_left", 64'(wq_a.size()), 64'd0);
        check("abort_reads_left", 64'(rq.size()), 64'd0);
        repeat (2) @(negedge clk);
        check("abort_mem61", {32'd0, mem[61]}, 64'd2);
        check("abort_mem62", {32'd0, mem[62]}, 64'd0);
        rst_n = 1'b1;
        push_w(8'd90, 32'h55);
        launch(1'b1, 8'd0, 8'd90, 9'd1, 32'h55, 2);
        finish("after_abort", 2);
        check("after_abort_mem90", {32'd0, mem[90]}, 64'h55);

        // Full 256-word fill exercises the extra index bit.
        for (int k = 0; k < 256; k++) push_w(8'(128 + k), 32'h0F0F0F0F);
        launch(1'b1, 8'd0, 8'd128, 9'd256, 32'h0F0F0F0F, 257);
        finish("fill256", 257);
        check("fill256_mem127", {32'd0, mem[127]}, 64'h0F0F0F0F);
        check("fill256_mem128", {32'd0, mem[128]}, 64'h0F0F0F0F);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
